// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: operation codes from the
// ALU control decoder, FSM state encoding and the default datapath width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_NOR = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Every code with the top bit set is outside the defined operation set.
  function automatic logic is_legal(input logic [3:0] code);
    return ~code[3];
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// done_o is high during the final iteration; product_o is valid while done_o is high.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  // The last partial sum is handed out combinationally so the caller can
  // capture it on the same edge that retires the final iteration.
  assign done_o    = busy_q && (cnt_q == CNT_W'(1));
  assign product_o = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (clear_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= CNT_W'(MUL_CYCLES);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops, iterative multiply,
// valid/ready handshakes on both sides and a synchronous pipeline flush.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUcnt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;

  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_res_d;
  logic             illegal_d;

  function automatic logic [WIDTH-1:0] alu_eval(input logic [3:0]       op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (op)
      ALU_ADD: alu_eval = x + y;
      ALU_SUB: alu_eval = x - y;
      ALU_AND: alu_eval = x & y;
      ALU_OR:  alu_eval = x | y;
      ALU_XOR: alu_eval = x ^ y;
      ALU_NOR: alu_eval = ~(x | y);
      ALU_SLT: alu_eval = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      default: alu_eval = '0;
    endcase
  endfunction

  // rst_n gates in_ready so nothing is offered while the unit is held in reset.
  assign in_ready  = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign is_mul    = (ALUcnt == ALU_MUL);
  assign alu_res_d = alu_eval(ALUcnt, a, b);
  assign illegal_d = !is_legal(ALUcnt);

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  alu_mul_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept && is_mul),
    .clear_i   (flush),
    .a_i       (a),
    .b_i       (b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && is_mul) begin
            state_q     <= ST_MUL;
            out_valid_q <= 1'b0;
          end else if (accept) begin
            result_q    <= alu_res_d;
            zero_q      <= (alu_res_d == '0);
            illegal_q   <= illegal_d;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            result_q    <= mul_product;
            zero_q      <= (mul_product == '0);
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
